// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encoding,
// host command codes and the widths of the time fields.
package stopwatch_pkg;

    // FSM states; values are visible on the debug LEDs.
    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    // Command codes carried on the 2-bit host/UART command port.
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_RS   = 2'd1,
        CMD_CLR  = 2'd2,
        CMD_LAP  = 2'd3
    } sw_cmd_e;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // True when a command strobe carries the given command code.
    function automatic logic cmd_hit(input logic valid, input logic [1:0] cmd,
                                     input sw_cmd_e code);
        return valid && (cmd == 2'(code));
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for a debounced button level. The one-flop history
// resets to 0, so a button held through reset yields one pulse after release.
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_pulse
);

    logic r_hist;

    // Remember last cycle's level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_hist <= 1'b0;
        else     r_hist <= i_level;
    end

    assign o_pulse = i_level & ~r_hist;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control unit: merges button edges and host commands into
// run/stop, clear and lap events, drives the datapath run enable and the
// clear pulse, and optionally freezes the displayed time on a lap.
// Optional feature macro: STOPWATCH_LAP_EN (LAP state and lap registers).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLEAR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_btn_runstop,
    input  logic              i_btn_clear,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    input  logic [MSEC_W-1:0] i_msec,
    input  logic [SEC_W-1:0]  i_sec,
    input  logic [MIN_W-1:0]  i_min,
    input  logic [HOUR_W-1:0] i_hour,
    output logic              o_runstop,
    output logic              o_clear,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_lap_active,
    output logic [1:0]        o_state
);

    localparam int              CNT_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

    logic             w_rs_edge;
    logic             w_clr_edge;
    logic             w_ev_rs;
    logic             w_ev_clr;
    sw_state_e        r_state;
    sw_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_runstop;
    logic             r_clear;

    btn_edge_detect u_edge_rs (
        .clk     (clk),
        .rst     (rst),
        .i_level (i_btn_runstop),
        .o_pulse (w_rs_edge)
    );

    btn_edge_detect u_edge_clr (
        .clk     (clk),
        .rst     (rst),
        .i_level (i_btn_clear),
        .o_pulse (w_clr_edge)
    );

    // A button edge and a command in the same cycle collapse into one event.
    assign w_ev_rs  = w_rs_edge  | cmd_hit(i_cmd_valid, i_cmd, CMD_RS);
    assign w_ev_clr = w_clr_edge | cmd_hit(i_cmd_valid, i_cmd, CMD_CLR);

`ifdef STOPWATCH_LAP_EN
    logic w_ev_lap;
    assign w_ev_lap = w_ev_clr | cmd_hit(i_cmd_valid, i_cmd, CMD_LAP);
`endif

    // Next-state logic with event priorities and the clear-length counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_STOP: begin
                if (w_ev_clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else if (w_ev_rs) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_ev_rs) begin
                    w_state_nxt = ST_STOP;
                end
`ifdef STOPWATCH_LAP_EN
                else if (w_ev_lap) begin
                    w_state_nxt = ST_LAP;
                end
`endif
            end
            ST_LAP: begin
`ifdef STOPWATCH_LAP_EN
                if (w_ev_rs) begin
                    w_state_nxt = ST_STOP;
                end else if (w_ev_lap) begin
                    w_state_nxt = ST_RUN;
                end
`else
                w_state_nxt = ST_STOP;
`endif
            end
            ST_CLEAR: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_STOP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_STOP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and Moore output flops; o_clear comes straight from r_clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_STOP;
            r_cnt     <= '0;
            r_runstop <= 1'b0;
            r_clear   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_runstop <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_LAP);
            r_clear   <= (w_state_nxt == ST_CLEAR);
        end
    end

    assign o_runstop = r_runstop;
    assign o_clear   = r_clear;
    assign o_state   = r_state;

`ifdef STOPWATCH_LAP_EN
    logic              r_lap;
    logic [MSEC_W-1:0] r_lap_msec;
    logic [SEC_W-1:0]  r_lap_sec;
    logic [MIN_W-1:0]  r_lap_min;
    logic [HOUR_W-1:0] r_lap_hour;

    // Lap flag tracks the LAP state as a dedicated flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lap <= 1'b0;
        else     r_lap <= (w_state_nxt == ST_LAP);
    end

    // Capture the live time on the edge that enters LAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap_msec <= '0;
            r_lap_sec  <= '0;
            r_lap_min  <= '0;
            r_lap_hour <= '0;
        end else if ((r_state != ST_LAP) && (w_state_nxt == ST_LAP)) begin
            r_lap_msec <= i_msec;
            r_lap_sec  <= i_sec;
            r_lap_min  <= i_min;
            r_lap_hour <= i_hour;
        end
    end

    // Display shows the frozen lap value while in LAP, live time otherwise.
    always_comb begin
        o_msec = i_msec;
        o_sec  = i_sec;
        o_min  = i_min;
        o_hour = i_hour;
        if (r_lap) begin
            o_msec = r_lap_msec;
            o_sec  = r_lap_sec;
            o_min  = r_lap_min;
            o_hour = r_lap_hour;
        end
    end

    assign o_lap_active = r_lap;
`else
    assign o_msec       = i_msec;
    assign o_sec        = i_sec;
    assign o_min        = i_min;
    assign o_hour       = i_hour;
    assign o_lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus steps a behavioural model and
// queues the expected outputs; a monitor pops and compares after each edge.
module tb_stopwatch_ctrl;

    localparam int CC = 2;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_btn_runstop = 1'b0;
    logic       i_btn_clear = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic [1:0] i_cmd = 2'd0;
    logic [6:0] i_msec = '0;
    logic [5:0] i_sec = '0;
    logic [5:0] i_min = '0;
    logic [4:0] i_hour = '0;
    logic       o_runstop, o_clear, o_lap_active;
    logic [6:0] o_msec;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic [1:0] o_state;

    stopwatch_ctrl #(.CLEAR_CYCLES(CC)) dut (
        .clk(clk), .rst(rst),
        .i_btn_runstop(i_btn_runstop), .i_btn_clear(i_btn_clear),
        .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .i_msec(i_msec), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
        .o_runstop(o_runstop), .o_clear(o_clear),
        .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
        .o_lap_active(o_lap_active), .o_state(o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int rs; int clr; int lap;
        int ms; int s; int m; int h;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Behavioural model: stopwatch is running or not, may be showing a frozen
    // lap, or is counting down a clear pulse.
    bit m_running, m_lapped, m_prev_rs, m_prev_clr;
    int m_clear_left;
    int lap_ms, lap_s, lap_m, lap_h;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_running = 0; m_lapped = 0; m_prev_rs = 0; m_prev_clr = 0;
        m_clear_left = 0; lap_ms = 0; lap_s = 0; lap_m = 0; lap_h = 0;
    endtask

    // Apply inputs now, advance the model across the coming edge, queue expectation.
    task automatic apply(input bit brs, input bit bclr, input bit cv, input int cmd,
                         input int ms, input int s, input int m, input int h);
        bit ev_rs, ev_clr, ev_lap;
        exp_t e;
        i_btn_runstop = brs; i_btn_clear = bclr; i_cmd_valid = cv; i_cmd = 2'(cmd);
        i_msec = 7'(ms); i_sec = 6'(s); i_min = 6'(m); i_hour = 5'(h);
        ev_rs  = (brs && !m_prev_rs)  || (cv && cmd == 1);
        ev_clr = (bclr && !m_prev_clr) || (cv && cmd == 2);
        ev_lap = ev_clr || (cv && cmd == 3);
        m_prev_rs = brs; m_prev_clr = bclr;
        if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (m_lapped) begin
            m_lapped = 0;
            if (ev_rs) m_running = 0;
            else if (!ev_lap) m_lapped = 1;
        end else if (m_running) begin
            if (ev_rs) m_running = 0;
            else if (ev_lap && LAP_EN) begin
                m_lapped = 1; lap_ms = ms; lap_s = s; lap_m = m; lap_h = h;
            end
        end else begin
            if (ev_clr) m_clear_left = CC;
            else if (ev_rs) m_running = 1;
        end
        e.st  = (m_clear_left > 0) ? 2 : m_lapped ? 3 : m_running ? 1 : 0;
        e.rs  = m_running;
        e.clr = (m_clear_left > 0);
        e.lap = m_lapped;
        e.ms  = m_lapped ? lap_ms : ms;
        e.s   = m_lapped ? lap_s  : s;
        e.m   = m_lapped ? lap_m  : m;
        e.h   = m_lapped ? lap_h  : h;
        q.push_back(e);
    endtask

    task automatic drive(input bit brs, input bit bclr, input bit cv, input int cmd,
                         input int ms, input int s, input int m, input int h);
        @(negedge clk);
        apply(brs, bclr, cv, cmd, ms, s, m, h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 5, 6, 7, 8);
    endtask

    // Monitor: every edge yields one output word to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state",    int'(o_state),      e.st);
                chk("runstop",  int'(o_runstop),    e.rs);
                chk("clear",    int'(o_clear),      e.clr);
                chk("lap",      int'(o_lap_active), e.lap);
                chk("msec",     int'(o_msec),       e.ms);
                chk("sec",      int'(o_sec),        e.s);
                chk("min",      int'(o_min),        e.m);
                chk("hour",     int'(o_hour),       e.h);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit brs, bclr;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_state",   int'(o_state),      0);
        chk("rst_runstop", int'(o_runstop),    0);
        chk("rst_clear",   int'(o_clear),      0);
        chk("rst_lap",     int'(o_lap_active), 0);
        @(negedge clk);
        rst = 1'b0;
        apply(0, 0, 0, 0, 1, 2, 3, 4);

        // Run/stop button edges, hold gives no extra toggle.
        drive(1, 0, 0, 0, 1, 2, 3, 4);
        repeat (3) drive(1, 0, 0, 0, 1, 2, 3, 4);
        drive(0, 0, 0, 0, 1, 2, 3, 4);
        drive(1, 0, 0, 0, 1, 2, 3, 4);
        drive(0, 0, 0, 0, 1, 2, 3, 4);

        // Command clear from STOP; button presses during the pulse ignored.
        drive(0, 0, 1, 2, 1, 2, 3, 4);
        drive(1, 1, 0, 0, 1, 2, 3, 4);
        drive(1, 1, 1, 1, 1, 2, 3, 4);
        drive(0, 0, 0, 0, 1, 2, 3, 4);
        idle(2);

        // Simultaneous run/stop and clear edges: STOP -> CLEAR, RUN -> STOP.
        drive(1, 1, 0, 0, 9, 9, 9, 9);
        drive(0, 0, 0, 0, 9, 9, 9, 9);
        idle(3);
        drive(1, 0, 0, 0, 9, 9, 9, 9);
        drive(0, 0, 0, 0, 9, 9, 9, 9);
        drive(1, 1, 0, 0, 9, 9, 9, 9);
        drive(0, 0, 0, 0, 9, 9, 9, 9);

        // Button edge and command together toggle only once.
        drive(1, 0, 1, 1, 9, 9, 9, 9);
        drive(0, 0, 0, 0, 9, 9, 9, 9);

        // Lap freeze from RUN, live time advancing, second clear releases.
        drive(0, 1, 0, 0, 34, 12, 1, 0);
        for (int i = 1; i < 5; i++) drive(0, 0, 0, 0, 34 + i, 12, 1, 0);
        drive(0, 1, 0, 0, 40, 13, 1, 0);
        drive(0, 0, 0, 0, 41, 13, 1, 0);
        drive(0, 0, 1, 3, 42, 13, 1, 0);
        drive(0, 0, 0, 0, 43, 14, 1, 0);
        drive(0, 0, 1, 3, 44, 14, 1, 0);
        drive(0, 0, 0, 0, 45, 14, 1, 0);
        drive(1, 0, 0, 0, 46, 14, 1, 0);
        drive(0, 0, 0, 0, 47, 14, 1, 0);

        // Reset asserted during the first cycle of CLEAR.
        drive(0, 0, 1, 2, 1, 1, 1, 1);
        @(posedge clk);
        #3;
        chk("clear_before_rst", int'(o_clear), 1);
        rst = 1'b1;
        i_cmd_valid = 1'b0;
        #1;
        chk("clear_async_drop", int'(o_clear),   0);
        chk("state_async_rst",  int'(o_state),   0);
        chk("rs_async_rst",     int'(o_runstop), 0);
        q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        apply(0, 0, 0, 0, 1, 1, 1, 1);
        idle(2);

        // Randomized phase.
        brs = 0; bclr = 0;
        for (int i = 0; i < 3000; i++) begin
            bit cv;
            if ($urandom_range(0, 5) == 0) brs = ~brs;
            if ($urandom_range(0, 7) == 0) bclr = ~bclr;
            cv = ($urandom_range(0, 3) == 0);
            drive(brs, bclr, cv, cv ? int'($urandom_range(0, 3)) : 0,
                  int'($urandom_range(0, 99)), int'($urandom_range(0, 59)),
                  int'($urandom_range(0, 59)), int'($urandom_range(0, 23)));
        end

        idle(2);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control unit for the stopwatch datapath. It turns debounced run/stop and clear buttons, plus a 2-bit command port (UART/host), into the datapath's `runstop` level and `clear` pulse. It also owns an optional lap-freeze of the displayed time. It sits between the button debouncers/command decoder and the stopwatch datapath, and feeds the display mux.

## Interface
Parameters:
- `CLEAR_CYCLES`, default 2: width of the `o_clear` pulse in clk cycles (≥1).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `i_btn_runstop`  in  1  debounced run/stop button level
- `i_btn_clear`  in  1  debounced clear/lap button level
- `i_cmd_valid`  in  1  command strobe, one cycle per command
- `i_cmd`  in  2  command: 00 none, 01 run/stop toggle, 10 clear, 11 lap
- `i_msec`/`i_sec`/`i_min`/`i_hour`  in  7/6/6/5  live datapath time
- `o_runstop`  out  1  datapath run enable
- `o_clear`  out  1  datapath synchronous-intent clear, driven straight from a flop
- `o_msec`/`o_sec`/`o_min`/`o_hour`  out  7/6/6/5  time for display
- `o_lap_active`  out  1  display frozen on lap value
- `o_state`  out  2  current FSM state, for debug LEDs

## Operation
- Event generation:
  - `ev_rs` = rising edge of `i_btn_runstop` OR (`i_cmd_valid` & `i_cmd`==01).
  - `ev_clr` = rising edge of `i_btn_clear` OR (`i_cmd_valid` & `i_cmd`==10).
  - `ev_lap` = `ev_clr` OR (`i_cmd_valid` & `i_cmd`==11).
  - Edge detection uses a one-flop history per button; the history resets to 0. A button held high through reset therefore produces one event after reset release.
- States: STOP=0, RUN=1, CLEAR=2, LAP=3.
  - STOP: `ev_clr` → CLEAR; else `ev_rs` → RUN; cmd 11 ignored.
  - RUN: `ev_rs` → STOP; else `ev_lap` → LAP.
  - LAP: `ev_rs` → STOP (lap released); else `ev_lap` → RUN (lap released).
  - CLEAR: all events ignored. Stays exactly `CLEAR_CYCLES` cycles, then → STOP.
- Priority in the same cycle:
  - In STOP, clear beats run/stop.
  - In RUN/LAP, run/stop beats lap.
  - A button event and a command in the same cycle merge into one event; no double toggle.
- Outputs are registered, Moore-style:
  - `o_runstop` = 1 in RUN or LAP.
  - `o_clear` = 1 only in CLEAR.
  - `o_lap_active` = 1 only in LAP.
- Display:
  - On entry to LAP, `i_msec..i_hour` are latched into lap registers on the same edge.
  - In LAP, `o_*` time = lap registers. Otherwise `o_*` time = `i_*`, combinational pass-through.
- Reset values: state STOP, `o_runstop`=0, `o_clear`=0, `o_lap_active`=0, lap registers 0, clear counter 0, edge history 0.
- Reset mid-CLEAR aborts the pulse immediately; `o_clear` goes 0 asynchronously.
- `o_clear` must be glitch-free because the datapath ORs it into an asynchronous reset. Its only source is the state/flag flop.

## Timing
- An input level/command present before edge k is acted on at edge k. The new `o_runstop`/`o_clear`/`o_lap_active` is visible after edge k (1-cycle latency).
- `o_clear` is high for exactly `CLEAR_CYCLES` consecutive cycles. `o_runstop`=0 throughout.
- Lap latch captures the `i_*` values sampled at the transition edge.
- After LAP release, `o_*` time shows live time in the cycle following the edge.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - LAP state and lap registers exist.
  - Behaviour as above.
- `STOPWATCH_LAP_EN` undefined:
  - No lap registers.
  - `ev_lap` in RUN is ignored, so clear in RUN does nothing and cmd 11 is always ignored.
  - LAP is unreachable.
  - `o_lap_active` is tied 0 and `o_*` time = `i_*` always.

## Structure
- `stopwatch_pkg`: state encoding (STOP/RUN/CLEAR/LAP), command codes (CMD_NONE/CMD_RS/CMD_CLR/CMD_LAP), time field widths 7/6/6/5.
- Sub-module `btn_edge_detect` (clk, rst, level in, one-cycle pulse out), instantiated twice.

## Test plan
- Reset, then a `i_btn_runstop` 0→1 edge → after that edge `o_runstop`=1, `o_state`=1. Holding the button high gives no further toggle. A second edge → `o_runstop`=0.
- From STOP, `i_cmd_valid`=1 with `i_cmd`=10 → `o_clear`=1 for exactly 2 cycles (default). Button presses during those cycles are ignored. Final state STOP.
- From STOP, run/stop and clear edges in the same cycle → CLEAR entered and `o_runstop` stays 0. From RUN, the same stimulus → STOP.
- LAP_EN: in RUN with `i_sec`=12, `i_msec`=34, pulse clear → `o_lap_active`=1 and `o_sec`/`o_msec` hold 12/34 while `i_*` advances; `o_runstop` stays 1. A second clear → live time returns and state is RUN.
- Assert `rst` during the first cycle of CLEAR → `o_clear` drops without waiting for clk; after release, state STOP with all outputs 0.
- Without LAP_EN: in RUN, clear edge and cmd 11 → no state change, and `o_*` time always equals `i_*`.
